mem_bridge8: RTL and testbench
==============================

MEM_BRIDGE8 -- requirements
Module: mem_bridge8

Interface
REQ-001 SHALL have parameter ADDR_W, default 20, external byte-memory address width.
REQ-002 SHALL have port clock  input  1  single clock; all logic on posedge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port core_a  input  32  core byte address.
REQ-005 SHALL have port core_o  input  32  core write data, byte k = core_o[8k+7:8k].
REQ-006 SHALL have port core_ws  input  2  write size: 0=1 byte, 1=2 bytes, 2 or 3=4 bytes.
REQ-007 SHALL have port core_w  input  1  write request.
REQ-008 SHALL have port core_i  output  32  registered read data to core.
REQ-009 SHALL have port core_ce  output  1  core clock-enable, one-cycle completion pulse.
REQ-010 SHALL have port mem_a  output  ADDR_W  byte address to external memory.
REQ-011 SHALL have port mem_q  input  8  memory read data, valid one cycle after mem_a.
REQ-012 SHALL have port mem_d  output  8  memory write data.
REQ-013 SHALL have port mem_we  output  1  memory write strobe.

Function
REQ-014 SHALL implement states IDLE, READ, WRITE, DONE; the core always presents a request, so every IDLE cycle starts a transaction.
REQ-015 IDLE SHALL latch base=core_a[ADDR_W-1:0], core_o, byte count n (1/2/4 from core_ws, or 4 when core_w=0), clear counter k, and go to WRITE if core_w=1, else READ.
REQ-016 READ SHALL drive mem_a=base+k for k=0..3 on consecutive cycles, then hold one extra cycle to capture the last byte.
REQ-017 READ SHALL store the mem_q byte returned for address base+k into core_i[8k+7:8k], little-endian.
REQ-018 A read SHALL span IDLE + 5 READ cycles, with core_ce=1 in the following DONE cycle (7th cycle).
REQ-019 WRITE SHALL assert mem_we=1 with mem_a=base+k and mem_d=byte k of latched core_o for k=0..n-1, one byte per cycle, then enter DONE.
REQ-020 Writes SHALL leave bytes at base+n..base+3 unwritten; core_i SHALL hold its previous value.
REQ-021 DONE SHALL assert core_ce=1 for exactly one cycle and return to IDLE; core_ce SHALL be 0 in all other states.
REQ-022 base+k SHALL wrap modulo 2^ADDR_W; core_a bits above ADDR_W-1 SHALL be ignored except per REQ-026.
REQ-023 mem_we SHALL be 0 outside WRITE; mem_a and mem_d SHALL hold their last values when idle.
REQ-024 Core inputs SHALL be sampled only in IDLE; changes during a transaction SHALL be ignored.

Reset
REQ-025 On any posedge with rst_n=0, state SHALL become IDLE and core_ce, mem_we, core_i, mem_a, mem_d, and k SHALL become 0; an in-flight transaction SHALL be abandoned without completion pulse; mem_we SHALL be low from that edge.

Configuration
REQ-026 With MEM_BRIDGE8_IO_EN defined, requests with core_a[31:28]=4'hF SHALL go to ports io_a (output 8, =core_a[7:0]), io_d (output 8, =core_o[7:0]), io_we (output 1), and io_q (input 8, combinational); they SHALL take one IO cycle, pulsing io_we for one cycle on writes or loading core_i={24'h0, io_q} on reads, then DONE, with no mem_we.
REQ-027 Without MEM_BRIDGE8_IO_EN, the io_* ports SHALL not exist and all addresses SHALL map to memory per REQ-022.

Verification
REQ-028 Memory holds 11,22,33,44 at 0x100..0x103; read core_a=0x100, core_w=0 -> core_i=0x44332211 with core_ce pulse on the 7th cycle, mem_we never high.
REQ-029 Write core_a=0x200, core_o=0xAABBCCDD, core_ws=2 -> 4 cycles with mem_we=1 writing DD,CC,BB,AA to 0x200..0x203, then core_ce pulse.
REQ-030 Write core_ws=0 at 0x300 with 0x12345678, and core_ws=1 at 0x304 with 0x0000BEEF -> 0x78 written at 0x300, EF,BE written at 0x304/0x305, neighbouring bytes unchanged.
REQ-031 Read core_a=0xFFFFE with ADDR_W=20 -> mem_a sequence FFFFE,FFFFF,00000,00001.
REQ-032 rst_n=0 during the 2nd byte of a 4-byte write -> mem_we=0 from that edge, no core_ce pulse, restart from IDLE after release.
REQ-033 With MEM_BRIDGE8_IO_EN, read 0xF0000010 with io_q=0x5A -> io_a=0x10, core_i=0x0000005A, core_ce on the 3rd cycle, mem_* inactive.

Source files
------------

// File: rtl/mem_bridge8.sv
// Bridges a 32-bit core request onto an 8-bit byte memory, one byte per cycle.
// Optional MEM_BRIDGE8_IO_EN routes core_a[31:28]==4'hF to a single-cycle io_* port.
module mem_bridge8 #(
  parameter int ADDR_W = 20
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic [31:0]       core_a,
  input  logic [31:0]       core_o,
  input  logic [1:0]        core_ws,
  input  logic              core_w,
  output logic [31:0]       core_i,
  output logic              core_ce,
  output logic [ADDR_W-1:0] mem_a,
  input  logic [7:0]        mem_q,
  output logic [7:0]        mem_d,
  output logic              mem_we
`ifdef MEM_BRIDGE8_IO_EN
  ,
  output logic [7:0]        io_a,
  output logic [7:0]        io_d,
  output logic              io_we,
  input  logic [7:0]        io_q
`endif
);

  typedef enum logic [2:0] {IDLE, READ, WRITE, DONE, IO} state_t;

  state_t            r_state;
  state_t            w_stateNext;
  logic [2:0]        r_k;
  logic [2:0]        r_n;
  logic              r_isWrite;
  logic [ADDR_W-1:0] r_base;
  logic [31:0]       r_data;
  logic [31:0]       r_coreI;
  logic [ADDR_W-1:0] r_memA;
  logic [7:0]        r_memD;
  logic [2:0]        w_n;
  logic [2:0]        w_kNext;
  logic [ADDR_W-1:0] w_nextAddr;
  logic [31:0]       w_shifted;
  logic [7:0]        w_nextByte;
  logic              w_isIo;
  logic              w_unused;

`ifdef MEM_BRIDGE8_IO_EN
  logic [7:0] r_ioA;
  logic [7:0] r_ioD;
  assign w_isIo = (core_a[31:28] == 4'hF);
  assign io_a   = r_ioA;
  assign io_d   = r_ioD;
  assign io_we  = (r_state == IO) && r_isWrite;
`else
  assign w_isIo = 1'b0;
`endif

  assign core_i     = r_coreI;
  assign mem_a      = r_memA;
  assign mem_d      = r_memD;
  assign w_kNext    = r_k + 3'd1;
  assign w_nextAddr = r_base + ADDR_W'(w_kNext);
  assign w_shifted  = r_data >> {w_kNext[1:0], 3'b000};
  assign w_nextByte = w_shifted[7:0];
  assign w_unused   = ^{core_a, w_shifted[31:8]};

  // Reads always fetch a full word; writes move 1, 2 or 4 bytes.
  always_comb begin
    w_n = 3'd4;
    if (core_w) begin
      case (core_ws)
        2'd0:    w_n = 3'd1;
        2'd1:    w_n = 3'd2;
        default: w_n = 3'd4;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_stateNext;
  end

  always_comb begin
    w_stateNext = r_state;
    core_ce     = 1'b0;
    mem_we      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_isIo)      w_stateNext = IO;
        else if (core_w) w_stateNext = WRITE;
        else             w_stateNext = READ;
      end
      READ: begin
        if (r_k == 3'd4) w_stateNext = DONE;
      end
      WRITE: begin
        mem_we = 1'b1;
        if (w_kNext == r_n) w_stateNext = DONE;
      end
      IO: begin
        w_stateNext = DONE;
      end
      DONE: begin
        core_ce     = 1'b1;
        w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // mem_q lags mem_a by a cycle, so READ step k captures the byte addressed at step k-1.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      r_k       <= 3'd0;
      r_n       <= 3'd4;
      r_isWrite <= 1'b0;
      r_base    <= '0;
      r_data    <= 32'h0;
      r_coreI   <= 32'h0;
      r_memA    <= '0;
      r_memD    <= 8'h0;
`ifdef MEM_BRIDGE8_IO_EN
      r_ioA     <= 8'h0;
      r_ioD     <= 8'h0;
`endif
    end else begin
      case (r_state)
        IDLE: begin
          r_base    <= core_a[ADDR_W-1:0];
          r_data    <= core_o;
          r_n       <= w_n;
          r_k       <= 3'd0;
          r_isWrite <= core_w;
          if (w_isIo) begin
`ifdef MEM_BRIDGE8_IO_EN
            r_ioA <= core_a[7:0];
            r_ioD <= core_o[7:0];
`endif
          end else begin
            r_memA <= core_a[ADDR_W-1:0];
            if (core_w) r_memD <= core_o[7:0];
          end
        end
        READ: begin
          r_k <= w_kNext;
          case (r_k)
            3'd1:    r_coreI[7:0]   <= mem_q;
            3'd2:    r_coreI[15:8]  <= mem_q;
            3'd3:    r_coreI[23:16] <= mem_q;
            3'd4:    r_coreI[31:24] <= mem_q;
            default: ;
          endcase
          if (r_k < 3'd3) r_memA <= w_nextAddr;
        end
        WRITE: begin
          r_k <= w_kNext;
          if (w_kNext < r_n) begin
            r_memA <= w_nextAddr;
            r_memD <= w_nextByte;
          end
        end
        IO: begin
`ifdef MEM_BRIDGE8_IO_EN
          if (!r_isWrite) r_coreI <= {24'h0, io_q};
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bridge8.sv
// Directed bench for mem_bridge8 with a byte-memory model and per-cycle trace capture.
// Define MEM_BRIDGE8_IO_EN to also exercise the IO window.
module tb_mem_bridge8;

  localparam int AW   = 20;
  localparam int MAXC = 12;

  logic          clock;
  logic          rst_n;
  logic [31:0]   core_a;
  logic [31:0]   core_o;
  logic [1:0]    core_ws;
  logic          core_w;
  logic [31:0]   core_i;
  logic          core_ce;
  logic [AW-1:0] mem_a;
  logic [7:0]    mem_q;
  logic [7:0]    mem_d;
  logic          mem_we;
`ifdef MEM_BRIDGE8_IO_EN
  logic [7:0]    io_a;
  logic [7:0]    io_d;
  logic          io_we;
  logic [7:0]    io_q;
`endif

  logic [7:0]    mem [0:(1<<AW)-1];
  logic [31:0]   trA [1:MAXC];
  logic [7:0]    trD [1:MAXC];
  logic [7:0]    trIoA [1:MAXC];
  logic [7:0]    trIoD [1:MAXC];
  int            weCount;
  int            ioWeCount;
  int            ceCycle;
  int            compared;
  int            mismatched;

  mem_bridge8 #(.ADDR_W(AW)) dut (
    .clock   (clock),
    .rst_n   (rst_n),
    .core_a  (core_a),
    .core_o  (core_o),
    .core_ws (core_ws),
    .core_w  (core_w),
    .core_i  (core_i),
    .core_ce (core_ce),
    .mem_a   (mem_a),
    .mem_q   (mem_q),
    .mem_d   (mem_d),
    .mem_we  (mem_we)
`ifdef MEM_BRIDGE8_IO_EN
    ,
    .io_a    (io_a),
    .io_d    (io_d),
    .io_we   (io_we),
    .io_q    (io_q)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_we) mem[mem_a] <= mem_d;
    mem_q <= mem[mem_a];
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at the negedge of an IDLE cycle; traces until the core_ce pulse or MAXC cycles.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] o,
                               input logic [1:0] ws, input logic w);
    core_a    = a;
    core_o    = o;
    core_ws   = ws;
    core_w    = w;
    weCount   = 0;
    ioWeCount = 0;
    ceCycle   = 0;
    for (int c = 1; c <= MAXC; c++) begin
      if (c > 1) begin
        @(posedge clock);
        @(negedge clock);
      end
      trA[c] = 32'(mem_a);
      trD[c] = mem_d;
      trIoA[c] = 8'h0;
      trIoD[c] = 8'h0;
`ifdef MEM_BRIDGE8_IO_EN
      trIoA[c] = io_a;
      trIoD[c] = io_d;
      if (io_we) ioWeCount++;
`endif
      if (mem_we) weCount++;
      if (core_ce) begin
        ceCycle = c;
        break;
      end
    end
  endtask

  task automatic toIdle();
    @(posedge clock);
    @(negedge clock);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0]  wrBytes [0:3];
    logic [31:0] wrapAddr [0:3];
    compared   = 0;
    mismatched = 0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = 8'hEE;
    mem[32'h100] = 8'h11; mem[32'h101] = 8'h22; mem[32'h102] = 8'h33; mem[32'h103] = 8'h44;
    mem[32'hFFFFE] = 8'hA1; mem[32'hFFFFF] = 8'hB2; mem[32'h0] = 8'hC3; mem[32'h1] = 8'hD4;
    wrBytes[0] = 8'hDD; wrBytes[1] = 8'hCC; wrBytes[2] = 8'hBB; wrBytes[3] = 8'hAA;
    wrapAddr[0] = 32'hFFFFE; wrapAddr[1] = 32'hFFFFF; wrapAddr[2] = 32'h0; wrapAddr[3] = 32'h1;
    rst_n = 1'b0; core_a = 32'h0; core_o = 32'h0; core_ws = 2'd0; core_w = 1'b0;
`ifdef MEM_BRIDGE8_IO_EN
    io_q = 8'h00;
`endif
    repeat (3) @(posedge clock);
    @(negedge clock);
    checkOutput("rst_core_ce", 32'(core_ce), 32'h0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'h0);
    checkOutput("rst_mem_a", 32'(mem_a), 32'h0);
    checkOutput("rst_mem_d", 32'(mem_d), 32'h0);
    checkOutput("rst_core_i", core_i, 32'h0);
    rst_n = 1'b1;

    applyStimulus(32'h100, 32'h0, 2'd0, 1'b0);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("rd_mem_a%0d", i), trA[i+2], 32'h100 + 32'(i));
    checkOutput("rd_ce_cycle", 32'(ceCycle), 32'd7);
    checkOutput("rd_we_count", 32'(weCount), 32'd0);
    checkOutput("rd_core_i", core_i, 32'h44332211);
    toIdle();

    applyStimulus(32'h200, 32'hAABBCCDD, 2'd2, 1'b1);
    checkOutput("wr4_ce_cycle", 32'(ceCycle), 32'd6);
    checkOutput("wr4_we_count", 32'(weCount), 32'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("wr4_mem_a%0d", i), trA[i+2], 32'h200 + 32'(i));
      checkOutput($sformatf("wr4_mem_d%0d", i), 32'(trD[i+2]), 32'(wrBytes[i]));
      checkOutput($sformatf("wr4_mem%0d", i), 32'(mem[32'h200 + i]), 32'(wrBytes[i]));
    end
    checkOutput("wr4_core_i_hold", core_i, 32'h44332211);
    toIdle();

    applyStimulus(32'h300, 32'h12345678, 2'd0, 1'b1);
    checkOutput("wr1_ce_cycle", 32'(ceCycle), 32'd3);
    checkOutput("wr1_we_count", 32'(weCount), 32'd1);
    checkOutput("wr1_mem300", 32'(mem[32'h300]), 32'h78);
    checkOutput("wr1_mem301", 32'(mem[32'h301]), 32'hEE);
    toIdle();

    applyStimulus(32'h304, 32'h0000BEEF, 2'd1, 1'b1);
    checkOutput("wr2_ce_cycle", 32'(ceCycle), 32'd4);
    checkOutput("wr2_mem303", 32'(mem[32'h303]), 32'hEE);
    checkOutput("wr2_mem304", 32'(mem[32'h304]), 32'hEF);
    checkOutput("wr2_mem305", 32'(mem[32'h305]), 32'hBE);
    checkOutput("wr2_mem306", 32'(mem[32'h306]), 32'hEE);
    toIdle();

    applyStimulus(32'h012FFFFE, 32'h0, 2'd1, 1'b0);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("wrap_mem_a%0d", i), trA[i+2], wrapAddr[i]);
    checkOutput("wrap_ce_cycle", 32'(ceCycle), 32'd7);
    checkOutput("wrap_core_i", core_i, 32'hD4C3B2A1);
    toIdle();

    core_a = 32'h400; core_o = 32'h01020304; core_ws = 2'd2; core_w = 1'b1;
    toIdle();
    toIdle();
    checkOutput("rstmid_we_before", 32'(mem_we), 32'h1);
    checkOutput("rstmid_a_before", 32'(mem_a), 32'h401);
    rst_n = 1'b0;
    toIdle();
    checkOutput("rstmid_mem_we", 32'(mem_we), 32'h0);
    checkOutput("rstmid_core_ce", 32'(core_ce), 32'h0);
    checkOutput("rstmid_mem_a", 32'(mem_a), 32'h0);
    checkOutput("rstmid_core_i", core_i, 32'h0);
    toIdle();
    checkOutput("rstmid_core_ce2", 32'(core_ce), 32'h0);
    rst_n = 1'b1;
    applyStimulus(32'h100, 32'h0, 2'd0, 1'b0);
    checkOutput("restart_ce_cycle", 32'(ceCycle), 32'd7);
    checkOutput("restart_core_i", core_i, 32'h44332211);
    checkOutput("rstmid_mem400", 32'(mem[32'h400]), 32'h04);
    checkOutput("rstmid_mem402", 32'(mem[32'h402]), 32'hEE);

`ifdef MEM_BRIDGE8_IO_EN
    toIdle();
    io_q = 8'h5A;
    applyStimulus(32'hF0000010, 32'h0, 2'd0, 1'b0);
    checkOutput("io_rd_ce_cycle", 32'(ceCycle), 32'd3);
    checkOutput("io_rd_io_a", 32'(trIoA[2]), 32'h10);
    checkOutput("io_rd_core_i", core_i, 32'h0000005A);
    checkOutput("io_rd_we_count", 32'(weCount), 32'd0);
    checkOutput("io_rd_mem_a_hold", trA[2], 32'h103);
    toIdle();
    applyStimulus(32'hF0000020, 32'h00000077, 2'd0, 1'b1);
    checkOutput("io_wr_ce_cycle", 32'(ceCycle), 32'd3);
    checkOutput("io_wr_io_we", 32'(ioWeCount), 32'd1);
    checkOutput("io_wr_io_d", 32'(trIoD[2]), 32'h77);
    checkOutput("io_wr_mem_we", 32'(weCount), 32'd0);
    checkOutput("io_wr_core_i_hold", core_i, 32'h0000005A);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
